// File: rtl/reset_sequencer.sv
// PLL-lock qualified reset sequencer: synchronise lock, wait for it to stay stable, hold core reset
// with the clock enable running, then release. Define RESET_SEQ_LOSS_COUNT_EN to add lock_loss_cnt.
module reset_sequencer #(
    parameter int unsigned LOCK_WAIT  = 1024,
    parameter int unsigned RESET_HOLD = 16,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    output logic       core_rst_n,
    output logic       core_clk_en,
    output logic       ready
`ifdef RESET_SEQ_LOSS_COUNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_WAIT - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RESET_HOLD - 1);
    localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILIZE,
        HOLD,
        RUN
    } state_e;

    state_e      state_q, state_d;
    logic        sync1_q;
    logic        lock_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  div_q, div_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        clk_en_q, clk_en_d;
    logic        ready_q, ready_d;
    logic        in_hr_q, in_hr_d;

`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic [7:0]  loss_q, loss_d;
`endif

    // State register, synchroniser and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            div_q        <= '0;
            core_rst_n_q <= 1'b0;
            clk_en_q     <= 1'b0;
            ready_q      <= 1'b0;
`ifdef RESET_SEQ_LOSS_COUNT_EN
            loss_q       <= '0;
`endif
        end else begin
            sync1_q      <= pll_lock;
            lock_s_q     <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            core_rst_n_q <= core_rst_n_d;
            clk_en_q     <= clk_en_d;
            ready_q      <= ready_d;
`ifdef RESET_SEQ_LOSS_COUNT_EN
            loss_q       <= loss_d;
`endif
        end
    end

    // Next-state logic; loss of lock wins over any terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s_q) state_d = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s_q) state_d = WAIT_LOCK;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so a lock loss clears them in the same update.
    always_comb begin
        in_hr_q      = (state_q == HOLD) || (state_q == RUN);
        in_hr_d      = (state_d == HOLD) || (state_d == RUN);
        div_d        = '0;
        if (in_hr_q && in_hr_d) begin
            div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        end
        clk_en_d     = in_hr_d && (div_q == DIV_LAST);
        core_rst_n_d = (state_d == RUN);
        ready_d      = (state_d == RUN);
`ifdef RESET_SEQ_LOSS_COUNT_EN
        loss_d = loss_q;
        if ((state_q == RUN) && (state_d == WAIT_LOCK) && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end
`endif
    end

    assign core_rst_n  = core_rst_n_q;
    assign core_clk_en = clk_en_q;
    assign ready       = ready_q;
`ifdef RESET_SEQ_LOSS_COUNT_EN
    assign lock_loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three parameterisations driven in parallel, checked every cycle
// against a run-length model of the synchronised lock, plus directed literal latency/pattern checks.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic pll_lock;

    logic [2:0] rstn_o, en_o, rdy_o;
`ifdef RESET_SEQ_LOSS_COUNT_EN
    logic [7:0] loss_o [3];
`endif

    int lw [3] = '{8, 8, 5};
    int rh [3] = '{4, 4, 3};
    int dv [3] = '{2, 3, 1};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reset_sequencer #(.LOCK_WAIT(8), .RESET_HOLD(4), .CLK_DIV(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .core_rst_n(rstn_o[0]), .core_clk_en(en_o[0]), .ready(rdy_o[0])
`ifdef RESET_SEQ_LOSS_COUNT_EN
        , .lock_loss_cnt(loss_o[0])
`endif
    );

    reset_sequencer #(.LOCK_WAIT(8), .RESET_HOLD(4), .CLK_DIV(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .core_rst_n(rstn_o[1]), .core_clk_en(en_o[1]), .ready(rdy_o[1])
`ifdef RESET_SEQ_LOSS_COUNT_EN
        , .lock_loss_cnt(loss_o[1])
`endif
    );

    reset_sequencer #(.LOCK_WAIT(5), .RESET_HOLD(3), .CLK_DIV(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .core_rst_n(rstn_o[2]), .core_clk_en(en_o[2]), .ready(rdy_o[2])
`ifdef RESET_SEQ_LOSS_COUNT_EN
        , .lock_loss_cnt(loss_o[2])
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // r = number of consecutive clock edges at which the synchronised lock was seen high.
    // Everything observable follows from r: reset released once r exceeds LOCK_WAIT+RESET_HOLD,
    // enable pulses every CLK_DIV edges counted from the edge that entered the hold phase.
    function automatic logic [2:0] exp_out(input int r, input int l, input int h, input int d);
        int  k;
        logic en;
        k  = r - l;
        en = 1'b0;
        if (k >= 1) en = (d == 1) || (k > 1 && ((k - 1) % d) == 0);
        return {(r > l + h), en, (r > l + h)};
    endfunction

    logic m_s1, m_s2;
    int   r_run = 0;
    int   loss_m [3] = '{0, 0, 0};
    bit   armed = 1'b0;

    always @(posedge clk) begin
        logic [2:0] e;
        if (!rst_n) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            r_run = 0;
            for (int i = 0; i < 3; i++) loss_m[i] = 0;
            armed = 1'b1;
        end else begin
            for (int i = 0; i < 3; i++)
                if (!m_s2 && r_run > lw[i] + rh[i] && loss_m[i] < 255) loss_m[i]++;
            r_run = m_s2 ? r_run + 1 : 0;
            m_s2  = m_s1;
            m_s1  = pll_lock;
        end
        #1;
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                e = exp_out(r_run, lw[i], rh[i], dv[i]);
                chk($sformatf("model core_rst_n[%0d]", i), int'(rstn_o[i]), int'(e[2]));
                chk($sformatf("model core_clk_en[%0d]", i), int'(en_o[i]), int'(e[1]));
                chk($sformatf("model ready[%0d]", i), int'(rdy_o[i]), int'(e[0]));
`ifdef RESET_SEQ_LOSS_COUNT_EN
                chk($sformatf("model lock_loss_cnt[%0d]", i), int'(loss_o[i]), loss_m[i]);
`endif
            end
        end
    end

    // Counts edges from the current negedge until each instance raises core_rst_n; 0 = never.
    task automatic measure_rise(input string tag, input int e0, input int e1, input int e2);
        int first [3];
        for (int i = 0; i < 3; i++) first[i] = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (rstn_o[i] && first[i] == 0) first[i] = k;
        end
        chk({tag, " rise d2"}, first[0], e0);
        chk({tag, " rise d3"}, first[1], e1);
        chk({tag, " rise d1"}, first[2], e2);
    endtask

    initial begin
        logic [5:0] v2, v3, v1;
        int hold_left;
        int fall;

        rst_n    = 1'b0;
        pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset core_rst_n", int'(rstn_o), 0);
        chk("reset core_clk_en", int'(en_o), 0);
        chk("reset ready", int'(rdy_o), 0);

        // Constant lock from reset release: 2 + 1 + LOCK_WAIT + RESET_HOLD edges.
        rst_n    = 1'b1;
        pll_lock = 1'b1;
        measure_rise("startup", 15, 15, 11);

        v2 = '0; v3 = '0; v1 = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            v2 = {v2[4:0], en_o[0]};
            v3 = {v3[4:0], en_o[1]};
            v1 = {v1[4:0], en_o[2]};
        end
        chk("div2 pattern", int'(v2), int'(6'b101010));
        chk("div3 pattern", int'(v3), int'(6'b100100));
        chk("div1 pattern", int'(v1), int'(6'b111111));

        // Lock loss in RUN: outputs clear three edges later.
        @(negedge clk);
        pll_lock = 1'b0;
        fall = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (!rstn_o[0] && fall == 0) begin
                fall = k;
                chk("loss ready", int'(rdy_o), 0);
                chk("loss core_clk_en", int'(en_o), 0);
            end
        end
        chk("loss latency", fall, 3);
`ifdef RESET_SEQ_LOSS_COUNT_EN
        chk("loss count first", int'(loss_o[0]), 1);
`endif

        // One-cycle lock glitch during STABILIZE count 5 restarts the full count.
        @(negedge clk);
        pll_lock = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        measure_rise("glitch", 15, 15, 11);

        // One-cycle rst_n pulse while in RUN.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst in RUN core_rst_n", int'(rstn_o), 0);
        chk("rst in RUN core_clk_en", int'(en_o), 0);
        chk("rst in RUN ready", int'(rdy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        measure_rise("rerun", 15, 15, 11);

        // Random lock behaviour with occasional resets.
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold_left == 0) begin
                pll_lock  = ~pll_lock;
                hold_left = pll_lock ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4));
            end else begin
                hold_left--;
            end
            rst_n = ($urandom_range(0, 199) != 0);
        end

        // Repeated lock-loss events to drive the loss counter into saturation.
        @(negedge clk);
        rst_n = 1'b1;
        for (int ev = 0; ev < 260; ev++) begin
            pll_lock = 1'b1;
            repeat (20) @(negedge clk);
            pll_lock = 1'b0;
            repeat (4) @(negedge clk);
        end
`ifdef RESET_SEQ_LOSS_COUNT_EN
        chk("loss saturate d2", int'(loss_o[0]), 255);
        chk("loss saturate d1", int'(loss_o[2]), 255);
`endif
        chk("after stress core_rst_n", int'(rstn_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
